instr_rom: RTL and testbench

//   Read-only instruction memory for the single-cycle LEGv8 datapath: 64 x 32-bit words,

---
 rtl/imem_pkg.sv | 31 +++
 rtl/instr_rom_core.sv | 12 +
 rtl/instr_rom.sv | 49 ++++
 tb/tb_instr_rom.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants, instruction type and the fixed self-check program image
// for the LEGv8 instruction memory.
package imem_pkg;

  localparam int IMEM_AW    = 6;
  localparam int IMEM_DW    = 32;
  localparam int IMEM_DEPTH = 64;

  typedef logic [IMEM_DW-1:0] instr_t;

  // Words 47..63 are unused by the program and read back as zero.
  localparam instr_t PROGRAM [0:IMEM_DEPTH-1] = '{
    32'hf8000001, 32'hf8008002, 32'hf8000203, 32'h8b050083,
    32'hf8018003, 32'hcb050083, 32'hf8020003, 32'hcb0a03e4,
    32'hf8028004, 32'h8b040064, 32'hf8030004, 32'hcb030025,
    32'hf8038005, 32'h8a1f0145, 32'hf8040005, 32'h8a030145,
    32'hf8048005, 32'h8a140294, 32'hf8050014, 32'haa1f0166,
    32'hf8058006, 32'haa030166, 32'hf8060006, 32'hf840000c,
    32'h8b1f0187, 32'hf8068007, 32'hf807000c, 32'h8b0e01bf,
    32'hf807801f, 32'hb4000040, 32'hf8080015, 32'hf8088015,
    32'h8b0103e2, 32'hcb010042, 32'h8b0103f8, 32'hf8090018,
    32'h8b080000, 32'hb4ffff82, 32'hf809001e, 32'h8b1e03de,
    32'hcb1503f5, 32'h8b1403de, 32'hf85f83d9, 32'h8b1e03de,
    32'h8b1003de, 32'hf81f83d9, 32'hb400001f, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
  };

endpackage

// File: rtl/instr_rom_core.sv
// Pure combinational lookup into the fixed program image.
module instr_rom_core
  import imem_pkg::*;
(
  input  logic [IMEM_AW-1:0] addr,
  output instr_t             q
);

  // An X on any address bit yields an X word rather than aliasing to a real entry.
  assign q = PROGRAM[addr];

endmodule

// File: rtl/instr_rom.sv
// LEGv8 instruction memory: 64 x 32-bit read-only words with an optional
// one-cycle registered output stage.
module instr_rom
  import imem_pkg::*;
#(
  parameter bit REG_OUT = 1'b0,
  parameter int DEPTH   = IMEM_DEPTH,
  parameter int AW      = IMEM_AW,
  parameter int DW      = IMEM_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] q
);

  localparam bit unused_depth_ok = (DEPTH == (1 << AW));

  instr_t rom_q;

  instr_rom_core u_core (
    .addr (addr),
    .q    (rom_q)
  );

  generate
    if (REG_OUT) begin : g_reg
      logic [DW-1:0] q_reg;

      // NOTE: sequential state is written with <= so every flop samples
      // pre-edge values; the image itself is constant and needs no reset.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q_reg <= '0;
        end else begin
          q_reg <= rom_q;
        end
      end

      assign q = q_reg;
    end else begin : g_comb
      // Clock and reset have no role in the combinational variant.
      logic unused_ctl;
      assign unused_ctl = clk ^ reset;
      assign q          = rom_q;
    end
  endgenerate

endmodule

// File: tb/tb_instr_rom.sv
// Self-checking bench: one combinational and one registered instance, with a
// scoreboard queue of expected words drained as outputs are sampled.
module tb_instr_rom;

  logic        clk;
  logic        reset;
  logic [5:0]  addr_c;
  logic [5:0]  addr_r;
  logic [31:0] q_c;
  logic [31:0] q_r;

  int total;
  int bad;

  logic [31:0] sb [$];

  localparam logic [31:0] PROG [0:46] = '{
    32'hf8000001, 32'hf8008002, 32'hf8000203, 32'h8b050083, 32'hf8018003, 32'hcb050083,
    32'hf8020003, 32'hcb0a03e4, 32'hf8028004, 32'h8b040064, 32'hf8030004, 32'hcb030025,
    32'hf8038005, 32'h8a1f0145, 32'hf8040005, 32'h8a030145, 32'hf8048005, 32'h8a140294,
    32'hf8050014, 32'haa1f0166, 32'hf8058006, 32'haa030166, 32'hf8060006, 32'hf840000c,
    32'h8b1f0187, 32'hf8068007, 32'hf807000c, 32'h8b0e01bf, 32'hf807801f, 32'hb4000040,
    32'hf8080015, 32'hf8088015, 32'h8b0103e2, 32'hcb010042, 32'h8b0103f8, 32'hf8090018,
    32'h8b080000, 32'hb4ffff82, 32'hf809001e, 32'h8b1e03de, 32'hcb1503f5, 32'h8b1403de,
    32'hf85f83d9, 32'h8b1e03de, 32'h8b1003de, 32'hf81f83d9, 32'hb400001f
  };

  instr_rom #(.REG_OUT(1'b0)) u_comb (
    .clk   (clk),
    .reset (reset),
    .addr  (addr_c),
    .q     (q_c)
  );

  instr_rom #(.REG_OUT(1'b1)) u_reg (
    .clk   (clk),
    .reset (reset),
    .addr  (addr_r),
    .q     (q_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input int a);
    return (a < 47) ? PROG[a] : 32'h0;
  endfunction

  // Pop the oldest expected word and compare it against an observed output.
  task automatic pop_cmp(input string name, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got %h", name, obs);
    end else begin
      e = sb.pop_front();
      if (obs !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h", name, obs, e);
      end
    end
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    total++;
    if (q_r !== 32'h0) begin
      bad++;
      $display("FAIL reset_hold: got %h want 00000000", q_r);
    end
    @(negedge clk);
    addr_r = 6'd5;
    reset  = 1'b0;
    #1;
    total++;
    if (q_r !== 32'h0) begin
      bad++;
      $display("FAIL reset_release_pre_edge: got %h want 00000000", q_r);
    end
    sb.push_back(32'hcb050083);
    @(posedge clk); #1;
    pop_cmp("reset_release_first_read", q_r);
  endtask

  task automatic test_comb_sweep;
    for (int a = 0; a < 64; a++) begin
      addr_c = 6'(a);
      sb.push_back(exp_word(a));
      #1;
      pop_cmp($sformatf("comb_sweep[%0d]", a), q_c);
      #9;
    end
  endtask

  task automatic test_spot;
    int addrs [6] = '{0, 3, 29, 46, 47, 63};
    logic [31:0] want [6] = '{32'hf8000001, 32'h8b050083, 32'hb4000040,
                              32'hb400001f, 32'h00000000, 32'h00000000};
    for (int i = 0; i < 6; i++) begin
      addr_c = 6'(addrs[i]);
      sb.push_back(want[i]);
      #1;
      pop_cmp($sformatf("spot[%0d]", addrs[i]), q_c);
      #4;
    end
  endtask

  task automatic test_midstream_reset;
    @(negedge clk);
    addr_r = 6'd9;
    @(posedge clk); #1;
    sb.push_back(32'h8b040064);
    pop_cmp("pre_midstream_read", q_r);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (q_r !== 32'h0) begin
      bad++;
      $display("FAIL midstream_reset_immediate: got %h want 00000000", q_r);
    end
    @(posedge clk); #1;
    total++;
    if (q_r !== 32'h0) begin
      bad++;
      $display("FAIL midstream_reset_edge: got %h want 00000000", q_r);
    end
    @(negedge clk);
    addr_r = 6'd17;
    reset  = 1'b0;
    sb.push_back(32'h8a140294);
    @(posedge clk); #1;
    pop_cmp("midstream_release_read", q_r);
  endtask

  task automatic test_latency;
    @(negedge clk);
    addr_r = 6'd0;
    sb.push_back(32'hf8000001);
    @(posedge clk); #1;
    pop_cmp("latency_addr0", q_r);
    @(negedge clk);
    addr_r = 6'd1;
    #1;
    sb.push_back(32'hf8000001);
    pop_cmp("latency_hold", q_r);
    sb.push_back(32'hf8008002);
    @(posedge clk); #1;
    pop_cmp("latency_addr1", q_r);
  endtask

  task automatic test_back_to_back;
    for (int a = 40; a < 52; a++) begin
      @(negedge clk);
      addr_r = 6'(a);
      sb.push_back(exp_word(a));
      @(posedge clk); #1;
      pop_cmp($sformatf("b2b[%0d]", a), q_r);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    addr_c = '0;
    addr_r = '0;
    test_comb_sweep();
    test_spot();
    test_reset();
    test_midstream_reset();
    test_latency();
    test_back_to_back();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
